// File: rtl/cpu1_mul_pkg.sv
// Shared definitions for the sequential multiply unit: op encodings, FSM
// states and the partial-product placement table.
package cpu1_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL = 2'b00;
  localparam logic [1:0] MUL_OP_XUU = 2'b01;
  localparam logic [1:0] MUL_OP_XSU = 2'b10;
  localparam logic [1:0] MUL_OP_XSS = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} mul_state_e;

  // Placement of pp_k in half-width units: aL*bL, aH*bL, aL*bH, aH*bH
  localparam int PP_SHIFT_HALVES [4] = '{0, 1, 1, 2};

  function automatic int pp_shift(input logic [1:0] k, input int hw);
    return PP_SHIFT_HALVES[k] * hw;
  endfunction

endpackage

// File: rtl/cpu1_mul_pp16.sv
// Half-width unsigned multiplier with one output register; kept separate so
// the DSP mapping can be swapped without touching the sequencer.
module cpu1_mul_pp16 #(
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  output logic [2*HW-1:0] p
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p <= '0;
    else       p <= {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
  end

endmodule

// File: rtl/cpu1_mul_seq.sv
// Multi-cycle multiply sequencer: four half-width partial products through one
// registered multiplier, accumulated into a double-width sum, then sign-corrected.
module cpu1_mul_seq
  import cpu1_mul_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit SKIP_HI_PP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int HW = DATA_W / 2;
  localparam int W2 = 2 * DATA_W;

  mul_state_e        state;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q, k_q, pp_idx;
  logic              pp_vld;
  logic [W2-1:0]     acc;
  logic [DATA_W-1:0] pp;

  logic              accept, issue;
  logic [1:0]        k_iss, k_last;
  logic [DATA_W-1:0] a_src, b_src, hi, corr;
  logic [HW-1:0]     pa, pb;
  logic [W2-1:0]     pp_ext;

  // pp0 is issued straight from the operand inputs in the accept cycle,
  // which is what lets mul finish in five cycles.
  assign accept = (state == IDLE) && start && !kill;
  assign issue  = accept || ((state == ISSUE) && !kill);
  assign k_iss  = accept ? 2'd0 : k_q;
  assign a_src  = accept ? src1 : a_q;
  assign b_src  = accept ? src2 : b_q;
  assign pa     = k_iss[0] ? a_src[DATA_W-1:HW] : a_src[HW-1:0];
  assign pb     = k_iss[1] ? b_src[DATA_W-1:HW] : b_src[HW-1:0];
  assign k_last = ((op_q == MUL_OP_MUL) && SKIP_HI_PP) ? 2'd2 : 2'd3;

  cpu1_mul_pp16 #(.HW(HW)) u_pp (
    .clk   (clk),
    .reset (reset),
    .a     (pa),
    .b     (pb),
    .p     (pp)
  );

  assign pp_ext = {{DATA_W{1'b0}}, pp} << pp_shift(pp_idx, HW);

  // Unsigned product high word -> signed: subtract the other operand for each negative signed input
  assign hi   = acc[W2-1:DATA_W];
  assign corr = (((op_q == MUL_OP_XSU) || (op_q == MUL_OP_XSS)) && a_q[DATA_W-1] ? b_q : '0)
              + ((op_q == MUL_OP_XSS) && b_q[DATA_W-1] ? a_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      k_q    <= '0;
      pp_idx <= '0;
      pp_vld <= 1'b0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      pp_vld <= issue;
      pp_idx <= k_iss;
      if (pp_vld) acc <= acc + pp_ext;
      if (kill && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            a_q   <= src1;
            b_q   <= src2;
            op_q  <= op;
            k_q   <= 2'd1;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
          ISSUE: begin
            if (k_q == k_last) state <= DRAIN;
            else               k_q   <= k_q + 2'd1;
          end
          DRAIN: state <= CORR;
          CORR: begin
            result <= (op_q == MUL_OP_MUL) ? acc[DATA_W-1:0] : hi - corr;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE: begin
            done  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu1_mul_seq.sv
// Bench for cpu1_mul_seq: directed vector table, handshake corner sequences and
// random ops checked against a sign-extend-and-multiply reference.
module tb_cpu1_mul_seq;

  localparam int W    = 32;
  localparam bit SKIP = 1;

  logic          clk = 1'b0;
  logic          reset, start, kill;
  logic [1:0]    op;
  logic [W-1:0]  src1, src2;
  logic          busy, done;
  logic [W-1:0]  result;

  always #5 clk = ~clk;

  cpu1_mul_seq #(.DATA_W(W), .SKIP_HI_PP(SKIP)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] last_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: extend each operand per its signedness, multiply mod 2^64, pick the word.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (o == 2'b10 || o == 2'b11) ea = {{32{a[31]}}, a};
    if (o == 2'b11)               eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    return (o == 2'b00 && SKIP) ? 5 : 6;
  endfunction

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int start_at);
    int cyc;
    bit busy_ok;
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_ok = 1'b1;
    op = 2'($urandom_range(3)); src1 = $urandom; src2 = $urandom;
    while (!done && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == start_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " latency"}, 64'(cyc), 64'(lat_of(o)));
    chk({name, " result"}, 64'(result), 64'(exp));
    chk({name, " busy in done cycle"}, 64'(busy), 64'd0);
    chk({name, " busy while in flight"}, 64'(busy_ok), 64'd1);
    last_res = exp;
    @(negedge clk);
    chk({name, " done one cycle"}, 64'(done), 64'd0);
  endtask

  task automatic no_done(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk({name, " quiet"}, 64'(seen), 64'd0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [W-1:0] pool[6];
    vt[0] = '{2'b00, 32'h00010003, 32'h00020005, 32'h000B000F};
    vt[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[2] = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vt[3] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[5] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vt[7] = '{2'b11, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
    vt[8] = '{2'b01, 32'h00000000, 32'h12345678, 32'h00000000};
    pool = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF};

    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    last_res = '0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 0);

    // Stray start in cycle 2 must be ignored
    run_op("start_while_busy", 2'b01, 32'h12345678, 32'h9ABCDEF0,
           model(2'b01, 32'h12345678, 32'h9ABCDEF0), 2);
    no_done("start_while_busy", 8);

    // Kill at cycle 3: abandon, keep result, then restart immediately
    op = 2'b00; src1 = 32'h11111111; src2 = 32'h22222222; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) kill = 1'b1;
      chk($sformatf("kill c%0d no done", c), 64'(done), 64'd0);
    end
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", 64'(busy), 64'd0);
    chk("kill done", 64'(done), 64'd0);
    chk("kill result held", 64'(result), 64'(last_res));
    run_op("after_kill", 2'b11, 32'hFFFFFFF0, 32'h00000010,
           model(2'b11, 32'hFFFFFFF0, 32'h00000010), 0);

    // Kill and start together in IDLE: nothing accepted
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill_start busy", 64'(busy), 64'd0);
    no_done("kill_start", 8);

    // Reset mid-op
    op = 2'b11; src1 = 32'hDEADBEEF; src2 = 32'hCAFEF00D; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    no_done("after_reset", 8);
    run_op("post_reset", 2'b10, 32'h80000001, 32'h00000003,
           model(2'b10, 32'h80000001, 32'h00000003), 0);

    // Random back-to-back ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(3));
      ra = ($urandom_range(3) == 0) ? pool[$urandom_range(5)] : $urandom;
      rb = ($urandom_range(3) == 0) ? pool[$urandom_range(5)] : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu1_mul_seq.md
Name: cpu1_mul_seq

Overview:
- Multi-cycle multiply sequencer for the CPU's multiply unit.
- Computes the full 64-bit product of two 32-bit operands by issuing four 16x16 unsigned partial products, one per cycle, to a single registered 16x16 multiplier, then accumulating and sign-correcting them.
- Returns the low word for mul, or the high word for mulxuu, mulxsu and mulxss.
- Sits between the A-stage operand registers and the writeback mux; uses a start/busy/done handshake with a kill input for pipeline flush.

Parameters:
DATA_W, 32, operand/result width; must be even; each half-width multiplier is DATA_W/2 bits
SKIP_HI_PP, 1, when 1, op mul skips the aH*bH partial product (saves one cycle)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when busy=0
kill  in  1  flush; abandons the current operation
op  in  2  00 mul (low word), 01 mulxuu, 10 mulxsu (src1 signed, src2 unsigned), 11 mulxss
src1  in  DATA_W  operand A
src2  in  DATA_W  operand B
busy  out  1  operation in flight
done  out  1  one-cycle pulse; result valid in the same cycle
result  out  DATA_W  product word; held until the next done

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, result=0; accumulator, counters and operand latches cleared.
- IDLE, start=1, kill=0: latch src1, src2 and op; busy=1 from the next cycle; go to ISSUE with issue index k=0.
- ISSUE: drive multiplier inputs with pair k in the order (aL,bL), (aH,bL), (aL,bH), (aH,bH).
  - Multiplier output is registered; pp_k is valid one cycle after issue.
  - Accumulate pp_k shifted left by 0, 16, 16, 32 bits respectively into a 64-bit accumulator, one cycle after it becomes valid.
  - Issue and accumulate overlap.
  - Issue count: 3 for op=00 with SKIP_HI_PP=1; 4 otherwise.
- DRAIN: wait for the last accumulate, then go to CORR.
- CORR: apply signed correction to accumulator bits [63:32], modulo 2^32.
  - mulxss: subtract (A[31] ? B : 0) + (B[31] ? A : 0).
  - mulxsu: subtract (A[31] ? B : 0).
  - mulxuu and mul: no correction.
  - Load result with acc[31:0] for mul, or the corrected acc[63:32] otherwise.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; busy drops to 0 in the same cycle; return to IDLE.
  - A start in this cycle is ignored; start is accepted only in IDLE.
- Latency, from the start-accept cycle (cycle 0) to the done cycle: 5 for mul (SKIP_HI_PP=1), 6 for mul (SKIP_HI_PP=0), 6 for mulxuu/mulxsu/mulxss.
- Back-to-back: a start in the cycle after done is accepted; throughput is one operation per latency+1 cycles.
- start while busy=1: ignored; no queueing, no error.
- kill=1 in any non-IDLE state: next state IDLE, busy=0, no done pulse, result unchanged.
  - kill in the DONE cycle: the done pulse still occurs (result already committed).
  - kill and start together in IDLE: kill wins; nothing is accepted.
- Operands and op are sampled only at accept; later changes on src1/src2/op have no effect.
- Reset asserted mid-operation: immediate clear; no done pulse after release.
- All arithmetic is unsigned modulo 2^64 in the accumulator; correction wraps modulo 2^32.

Decomposition:
- Shared package cpu1_mul_pkg holds:
  - op encoding constants MUL_OP_MUL/XUU/XSU/XSS;
  - state enum IDLE/ISSUE/DRAIN/CORR/DONE;
  - partial-product shift table.
- Sub-module cpu1_mul_pp16: 16x16 unsigned multiplier with a single output register, async clear on reset, 32-bit output.
  - Isolates the vendor DSP mapping from the sequencer.

Test Plan:
- mul: src1=0x00010003, src2=0x00020005, op=00 -> done exactly 5 cycles after accept, result=0x000B000F, busy high for cycles 1-4.
- mulxuu: 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 6, result=0xFFFFFFFE.
- mulxss pair:
  - 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFF.
  - 0x80000000 x 0x80000000 -> result=0x40000000.
- mulxsu: 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFF (product 0xFFFFFFFF_00000001).
- Handshake:
  - start pulsed at cycle 2 of an in-flight op -> ignored, exactly one done.
  - kill at cycle 3 -> no done, busy=0 next cycle, result keeps its prior value; new start next cycle completes normally.
- Reset mid-op: assert reset at cycle 2 for 1 cycle -> busy/done/result all 0 immediately; no done afterward; next start completes normally.
